pipe_spawner: RTL and testbench

Spawn-side counterpart to the pipe animation block. Decides when the next pipe enters and at what gap height. Drives the animator's spawn request (`mouse1`) and gap height (`pointY`), consumes its end-of-map pulse (`endOfMapPipe`), and maintains the game `score` fed back to the animator. Sits between the game-state logic and the pipe animator, clocked on the animation tick clock.

---
 rtl/pipe_game_pkg.sv | 23 ++
 rtl/pipe_lfsr16.sv | 25 ++
 rtl/pipe_spawner.sv | 112 +++++++++++
 tb/tb_pipe_spawner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_game_pkg.sv
// Shared types and constants for the pipe game spawn/animation blocks.
package pipe_game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GAP,
        ISSUE,
        WAIT_CLEAR
    } state_t;

    localparam int SCREEN_H = 480;
    localparam int SCORE_W  = 10;
    localparam int COORD_W  = 10;
    localparam int CNT_W    = 16;

    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pipe_lfsr16.sv
// Seedable 16-bit Fibonacci LFSR; exposes the low byte as the random value.
module pipe_lfsr16
    import pipe_game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic [7:0] o_rand
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_rand = r_lfsr[7:0];

endmodule

// File: rtl/pipe_spawner.sv
// Spawn sequencer: paces pipe requests to the animator, picks gap heights
// from an LFSR and keeps the saturating game score.
module pipe_spawner
    import pipe_game_pkg::*;
#(
    parameter int          GAP_Y_MIN     = 112,
    parameter int          BASE_INTERVAL = 90,
    parameter int          MIN_INTERVAL  = 40,
    parameter int          INTERVAL_STEP = 2,
    parameter int          SCORE_MAX     = 999,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               animationCLOCK,
    input  logic               reset,
    input  logic               gameRunning,
    input  logic               newGame,
    input  logic               pipeActive,
    input  logic               endOfMapPipe,
    output logic               mouse1,
    output logic [COORD_W-1:0] pointY,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         leds
);

    localparam int RANGE = BASE_INTERVAL - MIN_INTERVAL;

    state_t             r_state;
    logic               r_mouse1;
    logic [COORD_W-1:0] r_pointY;
    logic [SCORE_W-1:0] r_score;
    logic [CNT_W-1:0]   r_cnt;

    logic [7:0]         w_rand;
    logic [CNT_W-1:0]   w_red;
    logic [CNT_W-1:0]   w_interval;
    logic [COORD_W-1:0] w_gap_y;

    pipe_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk  (animationCLOCK),
        .i_rst  (reset),
        .i_en   (1'b1),
        .o_rand (w_rand)
    );

    // Interval shrinks with score and clamps at the floor.
    assign w_red      = CNT_W'(r_score) * CNT_W'(INTERVAL_STEP);
    assign w_interval = (w_red >= CNT_W'(RANGE))
                      ? CNT_W'(MIN_INTERVAL)
                      : CNT_W'(BASE_INTERVAL) - w_red;
    assign w_gap_y    = COORD_W'(GAP_Y_MIN) + {{(COORD_W-8){1'b0}}, w_rand};

    always_ff @(posedge animationCLOCK) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mouse1 <= 1'b0;
            r_pointY <= '0;
            r_cnt    <= '0;
        end else if (newGame || !gameRunning) begin
            r_state  <= IDLE;
            r_mouse1 <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt   <= w_interval;
                    r_state <= WAIT_GAP;
                end
                WAIT_GAP: begin
                    if (r_cnt == '0) begin
                        r_pointY <= w_gap_y;
                        r_mouse1 <= 1'b1;
                        r_state  <= ISSUE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (pipeActive) begin
                        r_mouse1 <= 1'b0;
                        r_state  <= WAIT_CLEAR;
                    end
                end
                WAIT_CLEAR: begin
                    if (!pipeActive) begin
                        r_cnt   <= w_interval;
                        r_state <= WAIT_GAP;
                    end
                end
                default: begin
                    r_mouse1 <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge animationCLOCK) begin
        if (reset || newGame) begin
            r_score <= '0;
        end else if (gameRunning && endOfMapPipe &&
                     r_score != SCORE_W'(SCORE_MAX)) begin
            r_score <= r_score + SCORE_W'(1);
        end
    end

    assign mouse1 = r_mouse1;
    assign pointY = r_pointY;
    assign score  = r_score;
    assign leds   = r_score[3:0];

endmodule

// File: tb/tb_pipe_spawner.sv
// Directed bench for pipe_spawner with a spawn scoreboard (due cycle, gap Y).
module tb_pipe_spawner;
    import pipe_game_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       gameRunning;
    logic       newGame;
    logic       pipeActive;
    logic       endOfMapPipe;
    logic       mouse1;
    logic [9:0] pointY;
    logic [9:0] score;
    logic [3:0] leds;

    typedef struct {
        int         due;
        logic [9:0] y;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          exp_score = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    pipe_spawner dut (
        .animationCLOCK (clk),
        .reset          (reset),
        .gameRunning    (gameRunning),
        .newGame        (newGame),
        .pipeActive     (pipeActive),
        .endOfMapPipe   (endOfMapPipe),
        .mouse1         (mouse1),
        .pointY         (pointY),
        .score          (score),
        .leds           (leds)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= reset ? 16'hACE1 : step(m_lfsr);
    end

    function automatic int exp_interval(input int s);
        return (s * 2 >= 50) ? 40 : 90 - s * 2;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge before the one that samples the trigger.
    task automatic push_spawn();
        exp_t        e;
        int          iv;
        logic [15:0] l;
        iv = exp_interval(exp_score);
        l  = m_lfsr;
        repeat (iv + 1) l = step(l);
        e.due = cyc + iv + 2;
        e.y   = 10'd112 + {2'b00, l[7:0]};
        q.push_back(e);
    endtask

    task automatic wait_spawn(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!mouse1 && n < 400) begin
            tick();
            n++;
        end
        if (q.size() == 0) begin
            chk({tag, " queue_empty"}, q.size(), 1);
        end else begin
            e = q.pop_front();
            chk({tag, " rise_cycle"}, cyc, e.due);
            chk({tag, " pointY"}, int'(pointY), int'(e.y));
        end
        chk({tag, " y_range"},
            int'(pointY >= 10'd112 && pointY <= 10'd367), 1);
        chk({tag, " lfsr_nz"}, int'(dut.u_lfsr.r_lfsr != 16'd0), 1);
    endtask

    task automatic pulse();
        endOfMapPipe = 1'b1;
        tick();
        endOfMapPipe = 1'b0;
        if (gameRunning && exp_score < 999) exp_score++;
    endtask

    initial begin
        logic [9:0] y0;
        reset        = 1'b1;
        gameRunning  = 1'b0;
        newGame      = 1'b0;
        pipeActive   = 1'b0;
        endOfMapPipe = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst mouse1", int'(mouse1), 0);
        chk("rst pointY", int'(pointY), 0);
        chk("rst score", int'(score), 0);
        chk("rst leds", int'(leds), 0);

        gameRunning = 1'b1;
        push_spawn();
        wait_spawn("first");
        y0 = pointY;
        repeat (2) begin
            tick();
            chk("hold mouse1", int'(mouse1), 1);
            chk("hold pointY", int'(pointY), int'(y0));
        end
        pipeActive = 1'b1;
        tick();
        chk("ack mouse1", int'(mouse1), 0);

        tick();
        pipeActive = 1'b0;
        push_spawn();
        wait_spawn("respawn0");
        pipeActive = 1'b1;
        tick();
        chk("one_cycle mouse1", int'(mouse1), 0);

        repeat (10) pulse();
        chk("score10", int'(score), 10);
        chk("leds10", int'(leds), 10);
        pipeActive = 1'b0;
        push_spawn();
        wait_spawn("iv70");
        pipeActive = 1'b1;
        tick();

        repeat (15) pulse();
        chk("score25", int'(score), 25);
        chk("leds25", int'(leds), 9);
        pipeActive = 1'b0;
        push_spawn();
        wait_spawn("iv40");
        pipeActive = 1'b1;
        tick();

        repeat (974) pulse();
        chk("score999", int'(score), 999);
        pulse();
        chk("score_sat", int'(score), 999);
        chk("leds_sat", int'(leds), 7);

        newGame      = 1'b1;
        endOfMapPipe = 1'b1;
        pipeActive   = 1'b0;
        tick();
        newGame      = 1'b0;
        endOfMapPipe = 1'b0;
        exp_score    = 0;
        chk("newgame score", int'(score), 0);
        chk("newgame mouse1", int'(mouse1), 0);
        push_spawn();
        wait_spawn("restart");

        gameRunning = 1'b0;
        tick();
        chk("stop mouse1", int'(mouse1), 0);
        chk("stop state", int'(dut.r_state), int'(IDLE));

        gameRunning = 1'b1;
        repeat (3) pulse();
        chk("score3", int'(score), 3);
        repeat (10) tick();
        chk("gap state", int'(dut.r_state), int'(WAIT_GAP));
        reset = 1'b1;
        tick();
        chk("mid_rst mouse1", int'(mouse1), 0);
        chk("mid_rst pointY", int'(pointY), 0);
        chk("mid_rst score", int'(score), 0);
        chk("mid_rst leds", int'(leds), 0);
        chk("mid_rst state", int'(dut.r_state), int'(IDLE));
        reset     = 1'b0;
        exp_score = 0;
        push_spawn();

        for (int i = 0; i < 256; i++) begin
            wait_spawn("bulk");
            pipeActive = 1'b1;
            tick();
            tick();
            pipeActive = 1'b0;
            if (i < 255) push_spawn();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
